operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-003 in_valid  in  1  upstream instruction valid.
REQ-004 in_ready  out  1  stage can accept; combinational from state and out_ready; 0 while reset asserted.
REQ-005 in_insn  in  32  instruction word; rs1 = in_insn[19:15], rs2 = in_insn[24:20].
REQ-006 rs1, rs2  out  5 each  regfile read addresses.
REQ-007 reg_rs1, reg_rs2  in  32 each  regfile read data, registered, valid the cycle after the address is sampled; x0 reads 0.
REQ-008 wen, waddr, wdata  in  1/5/32  writeback port, snooped in parallel with the regfile.
REQ-009 out_valid  out  1  operands valid downstream.
REQ-010 out_ready  in  1  downstream accepts.
REQ-011 out_insn, out_op1, out_op2  out  32 each  held instruction and operands.

Function
REQ-012 SHALL implement FSM IDLE, READ, VALID; reset state IDLE.
REQ-013 in_ready SHALL = (state==IDLE) | (state==VALID & out_ready).
REQ-014 Accept = in_valid & in_ready; on accept, latch in_insn and go to READ.
REQ-015 rs1/rs2 SHALL be driven from in_insn while in_ready=1, else from latched insn.
REQ-016 READ SHALL last exactly one cycle; at its end capture operands into out_op1/out_op2 and go to VALID.
REQ-017 out_valid SHALL be 1 only in VALID; latency accept edge -> out_valid = 2 cycles; max throughput 1 instruction per 2 cycles.
REQ-018 VALID & out_ready & !in_valid -> IDLE; VALID & out_ready & in_valid -> READ with new insn; VALID & !out_ready -> hold all outputs stable.
REQ-019 Outputs SHALL not change while out_valid=1 and out_ready=0, except REQ-022 forwarding.
REQ-020 Write at accept edge with wen & waddr!=0 & waddr==rs: latch wdata; at READ end use latched wdata instead of reg_rs.
REQ-021 Write at READ-end edge with matching nonzero waddr: capture wdata directly (newest wins over REQ-020).
REQ-022 In VALID, matching nonzero write SHALL update the held operand at that edge.
REQ-023 waddr==0 SHALL never forward; rs==0 operand SHALL be 0.
REQ-024 rs1==rs2 SHALL forward identically to both operands.

Reset
REQ-025 Asserted reset SHALL immediately force IDLE, out_valid=0, out_insn=0, out_op1=0, out_op2=0, forward latches cleared.
REQ-026 Reset mid-READ or mid-VALID SHALL discard the instruction; no output pulse after release.
REQ-027 First accept possible on the first rising edge after reset deasserts.

Configuration
REQ-028 Macro OPERAND_FETCH_BYPASS_EN defined: REQ-020..REQ-022 forwarding present.
REQ-029 Macro undefined: no snooping; wen/waddr/wdata unused; operands taken from reg_rs1/reg_rs2 only; the sequencer guarantees no write targets an in-flight source.

Verification
REQ-030 Reset, then insn rs1=1, rs2=2 with x1=5, x2=7, out_ready=1 -> out_valid 2 cycles after accept, op1=5, op2=7.
REQ-031 out_ready=0 for 4 cycles in VALID -> out_valid and outputs stable, in_ready=0; release -> single handoff.
REQ-032 BYPASS_EN: write x1=0xDEADBEEF at accept edge, rs1=1 -> op1=0xDEADBEEF; write at READ-end edge -> newest value; write to x0 -> op 0.
REQ-033 BYPASS_EN: in VALID with out_ready=0, write x2=0x42 -> op2 becomes 0x42 next cycle.
REQ-034 Back-to-back: in_valid held, out_ready=1 -> accepts every 2 cycles, in order, no drops.
REQ-035 Reset asserted during READ -> out_valid stays 0, outputs 0, in_ready=0 while reset asserted and 1 once released.

Source files
------------

// File: rtl/operand_fetch_if.sv
// operand_fetch_if -- bundle of every non-clock signal of the operand fetch stage.
//
// Signals:
//   in_valid/in_ready/in_insn    upstream instruction handshake
//   rs1/rs2                      register file read addresses (from the stage)
//   reg_rs1/reg_rs2              register file read data (one cycle after address)
//   wen/waddr/wdata              writeback port, snooped by the stage
//   out_valid/out_ready          downstream handshake
//   out_insn/out_op1/out_op2     held instruction and operands
//
// Modports:
//   slave  -- the operand_fetch stage itself
//   master -- its environment (upstream, register file, writeback, downstream)
interface operand_fetch_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_insn;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] reg_rs1;
  logic [31:0] reg_rs2;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_insn;
  logic [31:0] out_op1;
  logic [31:0] out_op2;

  modport slave (
    input  in_valid, in_insn, reg_rs1, reg_rs2, wen, waddr, wdata, out_ready,
    output in_ready, rs1, rs2, out_valid, out_insn, out_op1, out_op2
  );

  modport master (
    output in_valid, in_insn, reg_rs1, reg_rs2, wen, waddr, wdata, out_ready,
    input  in_ready, rs1, rs2, out_valid, out_insn, out_op1, out_op2
  );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch -- pipeline stage that reads both source operands of an
// instruction from a registered-read register file and hands the instruction
// plus operands downstream.
//
// Ports:
//   clk    sole clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    operand_fetch_if.slave (handshakes, regfile port, writeback snoop)
//
// Flow: IDLE --accept--> READ (one cycle, regfile data arrives) --> VALID
// (operands held until out_ready). A new instruction may be accepted in the
// same cycle the held one is handed off, giving one instruction per 2 cycles.
//
// Configuration macro: OPERAND_FETCH_BYPASS_EN
//   defined   -- writeback writes to a source register in flight are forwarded
//                (write at accept edge, at READ-end edge, and while held).
//   undefined -- no snooping; operands come from reg_rs1/reg_rs2 only.
module operand_fetch (
  input  logic           clk,
  input  logic           reset,
  operand_fetch_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] insn;
  logic [31:0] out_insn;
  logic [31:0] out_op1;
  logic [31:0] out_op2;
  logic [31:0] op1_next;
  logic [31:0] op2_next;
  logic        in_ready;
  logic        accept;

`ifdef OPERAND_FETCH_BYPASS_EN
  // Writes seen at the accept edge, replayed at the end of READ because the
  // register file read launched at that same edge returns the stale value.
  logic        fwd1_valid;
  logic        fwd2_valid;
  logic [31:0] fwd1_data;
  logic [31:0] fwd2_data;

  function automatic logic wb_hit(input logic wen, input logic [4:0] waddr,
                                  input logic [4:0] rs);
    return wen & (waddr != 5'd0) & (waddr == rs);
  endfunction
`else
  logic unused_wb;
  assign unused_wb = ^{bus.wen, bus.waddr, bus.wdata};
`endif

  // Gating with reset keeps the stage from advertising readiness while held.
  assign in_ready = ~reset & ((state == IDLE) | ((state == VALID) & bus.out_ready));
  assign accept   = bus.in_valid & in_ready;

  // Address the regfile from the incoming word while it can be sampled,
  // otherwise keep presenting the in-flight instruction's sources.
  assign bus.rs1 = in_ready ? bus.in_insn[19:15] : insn[19:15];
  assign bus.rs2 = in_ready ? bus.in_insn[24:20] : insn[24:20];

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == VALID);
  assign bus.out_insn  = out_insn;
  assign bus.out_op1   = out_op1;
  assign bus.out_op2   = out_op2;

  // Operand values to capture at the end of READ; newest write wins.
  always_comb begin
    op1_next = 32'd0;
    op2_next = 32'd0;
    if (insn[19:15] == 5'd0) begin
      op1_next = 32'd0;
    end
`ifdef OPERAND_FETCH_BYPASS_EN
    else if (wb_hit(bus.wen, bus.waddr, insn[19:15])) begin
      op1_next = bus.wdata;
    end else if (fwd1_valid) begin
      op1_next = fwd1_data;
    end
`endif
    else begin
      op1_next = bus.reg_rs1;
    end

    if (insn[24:20] == 5'd0) begin
      op2_next = 32'd0;
    end
`ifdef OPERAND_FETCH_BYPASS_EN
    else if (wb_hit(bus.wen, bus.waddr, insn[24:20])) begin
      op2_next = bus.wdata;
    end else if (fwd2_valid) begin
      op2_next = fwd2_data;
    end
`endif
    else begin
      op2_next = bus.reg_rs2;
    end
  end

`ifdef OPERAND_FETCH_BYPASS_EN
  // Forward latches: record a write to a source at the accept edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd1_valid <= 1'b0;
      fwd2_valid <= 1'b0;
      fwd1_data  <= 32'd0;
      fwd2_data  <= 32'd0;
    end else if (accept) begin
      fwd1_valid <= wb_hit(bus.wen, bus.waddr, bus.in_insn[19:15]);
      fwd2_valid <= wb_hit(bus.wen, bus.waddr, bus.in_insn[24:20]);
      fwd1_data  <= bus.wdata;
      fwd2_data  <= bus.wdata;
    end else if (state == READ) begin
      fwd1_valid <= 1'b0;
      fwd2_valid <= 1'b0;
    end else begin
      fwd1_valid <= fwd1_valid;
      fwd2_valid <= fwd2_valid;
    end
  end
`endif

  // Stage sequencer with registered instruction and operand outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      insn     <= 32'd0;
      out_insn <= 32'd0;
      out_op1  <= 32'd0;
      out_op2  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            insn  <= bus.in_insn;
            state <= READ;
          end else begin
            state <= IDLE;
          end
        end
        READ: begin
          out_insn <= insn;
          out_op1  <= op1_next;
          out_op2  <= op2_next;
          state    <= VALID;
        end
        VALID: begin
`ifdef OPERAND_FETCH_BYPASS_EN
          // Held operands track later writes to their source registers.
          if (wb_hit(bus.wen, bus.waddr, out_insn[19:15])) begin
            out_op1 <= bus.wdata;
          end else begin
            out_op1 <= out_op1;
          end
          if (wb_hit(bus.wen, bus.waddr, out_insn[24:20])) begin
            out_op2 <= bus.wdata;
          end else begin
            out_op2 <= out_op2;
          end
`endif
          if (accept) begin
            insn  <= bus.in_insn;
            state <= READ;
          end else if (bus.out_ready) begin
            state <= IDLE;
          end else begin
            state <= VALID;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch -- directed self-checking bench for operand_fetch.
// A register file model answers the read port; an architectural model
// (queue of accepted instructions + current register contents) predicts
// out_valid, in_ready and the held operands, checked every negative edge.
module tb_operand_fetch;

  logic clk = 1'b0;
  logic reset;
  logic init_en;

  operand_fetch_if bus ();

  operand_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] mk(input logic [4:0] a, input logic [4:0] b,
                                     input logic [4:0] tag);
    return {7'd0, b, a, 3'd0, tag, 7'h33};
  endfunction

  function automatic logic [31:0] init_val(input int i);
    if (i == 0) return 32'd0;
    else if (i == 1) return 32'd5;
    else if (i == 2) return 32'd7;
    else return 32'h1000_0000 | (32'(i) * 32'h111);
  endfunction

  // Register file: registered read, x0 reads zero, writes from writeback port.
  logic [31:0] regs [32];
  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < 32; i++) regs[i] <= init_val(i);
    end else if (bus.wen && bus.waddr != 5'd0) begin
      regs[bus.waddr] <= bus.wdata;
    end
    bus.reg_rs1 <= (bus.rs1 == 5'd0) ? 32'd0 : regs[bus.rs1];
    bus.reg_rs2 <= (bus.rs2 == 5'd0) ? 32'd0 : regs[bus.rs2];
  end

  function automatic logic [31:0] arch(input logic [4:0] r);
    return (r == 5'd0) ? 32'd0 : regs[r];
  endfunction

  // DUT handshake monitor (observed, not predicted).
  int mon_cyc = 0;
  int last_acc = 0;
  int n_acc = 0;
  int n_hand = 0;
  always @(posedge clk) begin
    mon_cyc <= mon_cyc + 1;
    if (!reset && bus.in_valid && bus.in_ready) begin
      last_acc <= mon_cyc;
      n_acc    <= n_acc + 1;
    end
    if (!reset && bus.out_valid && bus.out_ready) n_hand <= n_hand + 1;
  end

  // Architectural model: each accepted instruction becomes visible two
  // cycles after its accept cycle and stays until handed off.
  typedef struct {
    logic [31:0] insn;
    int          rdy;
  } ent_t;
  ent_t q[$];
  int cyc = 0;

  function automatic bit model_valid();
    return (q.size() > 0) && (q[0].rdy <= cyc);
  endfunction

  function automatic bit model_in_ready();
    return !reset && ((q.size() == 0) || (model_valid() && bus.out_ready));
  endfunction

  task automatic tick();
    bit v;
    bit r;
    @(posedge clk);
    v = model_valid();
    r = model_in_ready();
    if (reset) begin
      q.delete();
    end else begin
      if (v && bus.out_ready) void'(q.pop_front());
      if (r && bus.in_valid) q.push_back('{insn: bus.in_insn, rdy: cyc + 2});
    end
    cyc++;
    #1;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [31:0] hi;
    if (reset) begin
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("rst_out_insn", bus.out_insn, 32'd0);
      chk("rst_out_op1", bus.out_op1, 32'd0);
      chk("rst_out_op2", bus.out_op2, 32'd0);
    end else begin
      chk("cyc_out_valid", {31'd0, bus.out_valid}, {31'd0, model_valid()});
      chk("cyc_in_ready", {31'd0, bus.in_ready}, {31'd0, model_in_ready()});
      if (model_valid()) begin
        hi = q[0].insn;
        chk("cyc_out_insn", bus.out_insn, hi);
        chk("cyc_out_op1", bus.out_op1, arch(hi[19:15]));
        chk("cyc_out_op2", bus.out_op2, arch(hi[24:20]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1);
  end

  logic [31:0] list [5];

  initial begin
    int h0;
    int a0;
    int prev;
    reset = 1'b1;
    init_en = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_insn = 32'd0;
    bus.out_ready = 1'b0;
    bus.wen = 1'b0;
    bus.waddr = 5'd0;
    bus.wdata = 32'd0;
    tick(); tick();
    init_en = 1'b0;
    tick();
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("reset_out_op1", bus.out_op1, 32'd0);

    // Basic fetch: x1=5, x2=7, first accept right after reset release.
    reset = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_insn = mk(5'd1, 5'd2, 5'd1);
    bus.out_ready = 1'b1;
    #1;
    chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("idle_rs1_from_input", {27'd0, bus.rs1}, 32'd1);
    h0 = n_acc;
    tick();
    chk("first_edge_accept", n_acc - h0, 32'd1);
    bus.in_valid = 1'b0;
    bus.in_insn = mk(5'd9, 5'd9, 5'd0);
    #1;
    chk("read_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("read_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("read_rs1_latched", {27'd0, bus.rs1}, 32'd1);
    chk("read_rs2_latched", {27'd0, bus.rs2}, 32'd2);
    tick();
    chk("lat_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("lat_op1", bus.out_op1, 32'd5);
    chk("lat_op2", bus.out_op2, 32'd7);
    chk("lat_insn", bus.out_insn, mk(5'd1, 5'd2, 5'd1));
    tick();
    chk("handoff_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("handoff_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Backpressure: four stalled cycles, then exactly one handoff.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_insn = mk(5'd3, 5'd4, 5'd2);
    tick();
    bus.in_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("stall_op1", bus.out_op1, 32'h1000_0333);
      chk("stall_op2", bus.out_op2, 32'h1000_0444);
      tick();
    end
    h0 = n_hand;
    bus.out_ready = 1'b1;
    #1;
    chk("release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick(); tick(); tick();
    chk("single_handoff", n_hand - h0, 32'd1);
    chk("after_release_valid", {31'd0, bus.out_valid}, 32'd0);

    // Back-to-back stream: in_valid held, out_ready high.
    list[0] = mk(5'd5, 5'd6, 5'd3);
    list[1] = mk(5'd0, 5'd7, 5'd4);
    list[2] = mk(5'd8, 5'd8, 5'd5);
    list[3] = mk(5'd9, 5'd10, 5'd6);
    list[4] = mk(5'd31, 5'd0, 5'd7);
    h0 = n_hand;
    prev = 0;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.in_insn = list[k];
      a0 = n_acc;
      for (int t = 0; t < 6 && n_acc == a0; t++) tick();
      chk("b2b_accept", n_acc - a0, 32'd1);
      if (k > 0) chk("b2b_gap", last_acc - prev, 32'd2);
      prev = last_acc;
    end
    bus.in_valid = 1'b0;
    tick(); tick(); tick();
    chk("b2b_all_handed", n_hand - h0, 32'd5);

    // Reset while in READ.
    bus.in_valid = 1'b1;
    bus.in_insn = mk(5'd1, 5'd2, 5'd8);
    tick();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rstread_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rstread_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rstread_out_insn", bus.out_insn, 32'd0);
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rstread_release_ready", {31'd0, bus.in_ready}, 32'd1);
    h0 = n_hand;
    tick(); tick(); tick();
    chk("rstread_no_pulse", n_hand - h0, 32'd0);

    // Reset while in VALID (stalled).
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_insn = mk(5'd2, 5'd1, 5'd9);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("rstvalid_pre_valid", {31'd0, bus.out_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rstvalid_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rstvalid_op1", bus.out_op1, 32'd0);
    tick();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    h0 = n_hand;
    tick(); tick(); tick();
    chk("rstvalid_no_pulse", n_hand - h0, 32'd0);

`ifdef OPERAND_FETCH_BYPASS_EN
    // Write at accept edge, then a write while held and stalled.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_insn = mk(5'd1, 5'd2, 5'd10);
    bus.wen = 1'b1; bus.waddr = 5'd1; bus.wdata = 32'hDEAD_BEEF;
    tick();
    bus.in_valid = 1'b0; bus.wen = 1'b0;
    tick();
    chk("byp_accept_edge_op1", bus.out_op1, 32'hDEAD_BEEF);
    chk("byp_accept_edge_op2", bus.out_op2, 32'd7);
    bus.wen = 1'b1; bus.waddr = 5'd2; bus.wdata = 32'h0000_0042;
    tick();
    bus.wen = 1'b0;
    chk("byp_held_op2", bus.out_op2, 32'h0000_0042);
    chk("byp_held_op1", bus.out_op1, 32'hDEAD_BEEF);
    bus.out_ready = 1'b1;
    tick();

    // Accept-edge write superseded by a READ-end write.
    bus.in_valid = 1'b1;
    bus.in_insn = mk(5'd1, 5'd3, 5'd11);
    bus.wen = 1'b1; bus.waddr = 5'd1; bus.wdata = 32'h1111_1111;
    tick();
    bus.in_valid = 1'b0;
    bus.wdata = 32'h2222_2222;
    tick();
    bus.wen = 1'b0;
    chk("byp_newest_op1", bus.out_op1, 32'h2222_2222);
    chk("byp_newest_op2", bus.out_op2, 32'h1000_0333);
    tick();

    // Writes to x0 never forward.
    bus.in_valid = 1'b1;
    bus.in_insn = mk(5'd0, 5'd1, 5'd12);
    bus.wen = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hFFFF_FFFF;
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.wen = 1'b0;
    chk("byp_x0_op1", bus.out_op1, 32'd0);
    chk("byp_x0_op2", bus.out_op2, 32'h2222_2222);
    tick();

    // Same source for both operands.
    bus.in_valid = 1'b1;
    bus.in_insn = mk(5'd4, 5'd4, 5'd13);
    bus.wen = 1'b1; bus.waddr = 5'd4; bus.wdata = 32'hA5A5_A5A5;
    tick();
    bus.in_valid = 1'b0; bus.wen = 1'b0;
    tick();
    chk("byp_same_op1", bus.out_op1, 32'hA5A5_A5A5);
    chk("byp_same_op2", bus.out_op2, 32'hA5A5_A5A5);
    tick(); tick();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
